// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for MIPS-style multiply/divide and MTHI/MTLO.
// One shared iterative datapath: shift-add multiply, restoring divide.
module muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [5:0]       req_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             req_ready,
    input  logic             flush,
    input  logic             rd_hi_req,
    input  logic             rd_lo_req,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_orig;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz;

    logic               op_ok;
    logic               accept;
    logic               sgn;
    logic               op_mul;
    logic               op_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_val;
    logic [WIDTH-1:0]   b_val;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic               last;

    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE);
    assign stall     = busy & (rd_hi_req | rd_lo_req | req_valid);

    assign op_ok  = (req_op != '0) && ((req_op & (req_op - 6'd1)) == '0);
    assign accept = req_valid & req_ready & ~flush & op_ok;
    assign sgn    = req_op[0] | req_op[2];
    assign op_mul = req_op[0] | req_op[1];
    assign op_div = req_op[2] | req_op[3];
    assign a_neg  = sgn & src_a[WIDTH-1];
    assign b_neg  = sgn & src_b[WIDTH-1];
    assign a_val  = a_neg ? -src_a : src_a;
    assign b_val  = b_neg ? -src_b : src_b;

    // Multiply: acc_lo holds the unconsumed multiplier bits, acc_hi the partial sum.
    assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd};

    assign prod_s = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo_s  = neg_q ? -acc_lo : acc_lo;
    assign rem_s  = neg_r ? -acc_hi : acc_hi;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            a_orig <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            cnt    <= '0;
                            acc_hi <= '0;
                            a_orig <= src_a;
                            is_div <= op_div;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            dz     <= (src_b == '0);
                            unique case (1'b1)
                                req_op[5]: lo <= src_a;
                                req_op[4]: hi <= src_a;
                                op_mul: begin
                                    state  <= MUL;
                                    opnd   <= a_val;
                                    acc_lo <= b_val;
                                end
                                op_div: begin
                                    state  <= DIV;
                                    opnd   <= b_val;
                                    acc_lo <= a_val;
                                end
                            endcase
                        end
                    end
                    MUL: begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                        cnt   <= cnt + CNT_W'(1);
                        if (last) begin
                            state <= FIX;
                            cnt   <= '0;
                        end
                    end
                    DIV: begin
                        if (!div_trial[WIDTH]) begin
                            acc_hi <= div_trial[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            state <= FIX;
                            cnt   <= '0;
                        end
                    end
                    FIX: begin
                        if (!is_div) begin
                            {hi, lo} <= prod_s;
                        end else if (dz) begin
                            lo <= '1;
                            hi <= a_orig;
                        end else begin
                            lo <= quo_s;
                            hi <= rem_s;
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random ops
// checked against an arithmetic HI/LO model.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [5:0]  req_op = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        rd_hi_req = 1'b0;
    logic        rd_lo_req = 1'b0;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .src_a(src_a), .src_b(src_b), .req_ready(req_ready), .flush(flush),
        .rd_hi_req(rd_hi_req), .rd_lo_req(rd_lo_req), .stall(stall),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // op index: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo
    task automatic model(input int opi, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (opi)
            0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            1: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            2: if (b == 0) begin m_lo = '1; m_hi = a; end
               else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            3: if (b == 0) begin m_lo = '1; m_hi = a; end
               else begin m_lo = a / b; m_hi = a % b; end
            4: m_hi = a;
            default: m_lo = a;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an op for one cycle (T); returns in cycle T+1.
    task automatic start(input int opi, input logic [31:0] a, input logic [31:0] b);
        chk1("ready_before_op", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = 6'(1 << opi);
        src_a     = a;
        src_b     = b;
        step();
        req_valid = 1'b0;
        req_op    = '0;
    endtask

    task automatic run_op(input int opi, input logic [31:0] a, input logic [31:0] b,
                          input bit hold_rd);
        int k;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        rd_hi_req = hold_rd;
        start(opi, a, b);
        model(opi, a, b);
        if (opi >= 4) begin
            chk1("mt_busy", busy, 1'b0);
            chk1("mt_done", done, 1'b0);
            chk32("mt_hi", hi, m_hi);
            chk32("mt_lo", lo, m_lo);
            rd_hi_req = 1'b0;
            return;
        end
        chk1("ready_while_busy", req_ready, 1'b0);
        chk32("hi_held_during_op", hi, old_hi);
        chk32("lo_held_during_op", lo, old_lo);
        k = 1;
        while (!done && k < 40) begin
            if (hold_rd) chk1("stall_busy", stall, 1'b1);
            step();
            k++;
        end
        chk32("latency", 32'(k), 32'd34);
        chk1("busy_at_done", busy, 1'b0);
        chk1("ready_at_done", req_ready, 1'b1);
        if (hold_rd) chk1("stall_at_done", stall, 1'b0);
        chk32("hi_result", hi, m_hi);
        chk32("lo_result", lo, m_lo);
        rd_hi_req = 1'b0;
        step();
        chk1("done_one_cycle", done, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            4: return -32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        bit saw_done;

        // reset state, with readers and a request pending
        req_valid = 1'b1;
        rd_hi_req = 1'b1;
        req_op    = 6'b000001;
        #12;
        chk1("rst_ready", req_ready, 1'b1);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk32("rst_hi", hi, 32'h0);
        chk32("rst_lo", lo, 32'h0);
        req_valid = 1'b0;
        rd_hi_req = 1'b0;
        req_op    = '0;
        rst = 1'b0;
        step();

        // directed arithmetic cases
        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(0, -32'sd3, 32'd7, 1'b1);
        run_op(2, -32'sd7, 32'd2, 1'b0);
        run_op(3, 32'd100, 32'd7, 1'b0);
        run_op(3, 32'd5, 32'd0, 1'b0);
        run_op(2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2, -32'sd9, 32'd0, 1'b0);

        // mthi then an MFLO in the following cycle: no stall
        run_op(4, 32'h1234, 32'h0, 1'b0);
        rd_lo_req = 1'b1;
        #1;
        chk1("mflo_after_mthi_stall", stall, 1'b0);
        chk32("mthi_value", hi, 32'h1234);
        step();
        rd_lo_req = 1'b0;

        // malformed op codes are ignored
        req_valid = 1'b1;
        req_op    = 6'b000011;
        src_a     = 32'h55;
        step();
        chk1("multi_hot_ignored", busy, 1'b0);
        req_op = 6'b000000;
        step();
        chk1("zero_op_ignored", busy, 1'b0);
        chk32("ignored_hi", hi, m_hi);
        chk32("ignored_lo", lo, m_lo);

        // request coinciding with flush is dropped
        req_op = 6'b010000;
        flush  = 1'b1;
        step();
        req_valid = 1'b0;
        req_op    = '0;
        flush     = 1'b0;
        chk1("flush_drop_busy", busy, 1'b0);
        chk32("flush_drop_hi", hi, m_hi);

        // flush mid-multiply
        run_op(4, 32'hAA, 32'h0, 1'b0);
        run_op(5, 32'hAA, 32'h0, 1'b0);
        start(0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk1("flush_mid_busy", busy, 1'b0);
        chk1("flush_mid_ready", req_ready, 1'b1);
        chk32("flush_mid_hi", hi, 32'hAA);
        chk32("flush_mid_lo", lo, 32'hAA);
        saw_done = 1'b0;
        repeat (40) begin
            saw_done |= done;
            step();
        end
        chk1("flush_mid_no_done", saw_done, 1'b0);

        // flush while in the sign-fix cycle
        start(2, 32'd77, 32'd5);
        repeat (32) step();
        chk1("fix_still_busy", busy, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        saw_done = done;
        chk1("flush_fix_busy", busy, 1'b0);
        chk32("flush_fix_hi", hi, 32'hAA);
        chk32("flush_fix_lo", lo, 32'hAA);
        repeat (5) begin
            saw_done |= done;
            step();
        end
        chk1("flush_fix_no_done", saw_done, 1'b0);

        // async reset in the middle of a divide
        start(2, 32'd1000, 32'd3);
        repeat (19) step();
        rst = 1'b1;
        #1;
        chk32("rst_mid_hi", hi, 32'h0);
        chk32("rst_mid_lo", lo, 32'h0);
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_ready", req_ready, 1'b1);
        m_hi = '0;
        m_lo = '0;
        #2;
        rst = 1'b0;
        step();
        run_op(3, 32'd100, 32'd7, 1'b0);

        // random ops against the model
        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 5)), pick(), pick(), bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
